// File: rtl/sdram_arb_pkg.sv
// Shared types and default constants for the SDRAM command-port arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StBusy
  } arb_state_e;

  typedef enum logic {
    OwnRd = 1'b0,
    OwnWr = 1'b1
  } owner_e;

  localparam int unsigned BURST_LEN_DEFAULT   = 128;
  localparam int unsigned FRAME_WORDS_DEFAULT = 32640;

endpackage

// File: rtl/sdram_burst_addr_gen.sv
// Per-port burst start address: steps by BURST_LEN, wraps at one frame, rewinds to BASE on set.
module sdram_burst_addr_gen
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned BASE        = 0,
  parameter int unsigned BURST_LEN   = BURST_LEN_DEFAULT,
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set,
  input  logic              adv,
  input  logic              busy,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] StepAddr = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] WrapAddr = ADDR_W'(BASE + FRAME_WORDS);

  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic              pend_q, pend_d;

  always_comb begin
    addr_inc = addr_q + StepAddr;
    if (addr_inc == WrapAddr) begin
      addr_inc = BaseAddr;
    end
    addr_d = addr_q;
    pend_d = pend_q;
    if (adv) begin
      // A rewind requested during this port's burst replaces the step at burst end.
      addr_d = (pend_q || set) ? BaseAddr : addr_inc;
      pend_d = 1'b0;
    end else if (set) begin
      if (busy) begin
        pend_d = 1'b1;
      end else begin
        addr_d = BaseAddr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= BaseAddr;
      pend_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      pend_q <= pend_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Arbitrates the SDRAM command port between the LCD read path and the loader write path.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 24,
  parameter int unsigned BURST_LEN    = BURST_LEN_DEFAULT,
  parameter int unsigned FRAME_WORDS  = FRAME_WORDS_DEFAULT,
  parameter int unsigned RD_BASE      = 0,
  parameter int unsigned WR_BASE      = 0,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic              rd_addr_set,
  input  logic              wr_req,
  input  logic              wr_addr_set,
  output logic              sdr_req,
  output logic              sdr_we,
  output logic [ADDR_W-1:0] sdr_addr,
  input  logic              sdr_ack,
  input  logic              sdr_done,
  output logic              rd_grant,
  output logic              wr_grant
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [StarveW-1:0] starve_q, starve_d;

  logic              rd_sel, wr_sel;
  logic              rd_adv, wr_adv, rd_busy, wr_busy;
  logic [ADDR_W-1:0] rd_addr, wr_addr;

  assign rd_sel = rd_req && (!wr_req || (starve_q < StarveMax));
  assign wr_sel = !rd_sel && wr_req;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    starve_d = starve_q;
    unique case (state_q)
      StIdle: begin
        if (rd_sel) begin
          state_d = StReq;
          owner_d = OwnRd;
          we_d    = 1'b0;
          addr_d  = rd_addr;
          if (!wr_req) begin
            starve_d = '0;
          end else if (starve_q != StarveMax) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (wr_sel) begin
          state_d  = StReq;
          owner_d  = OwnWr;
          we_d     = 1'b1;
          addr_d   = wr_addr;
          starve_d = '0;
        end
      end
      StReq: begin
        if (sdr_ack) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (sdr_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      owner_q  <= OwnRd;
      we_q     <= 1'b0;
      addr_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      starve_q <= starve_d;
    end
  end

  assign rd_busy = (state_q != StIdle) && (owner_q == OwnRd);
  assign wr_busy = (state_q != StIdle) && (owner_q == OwnWr);
  assign rd_adv  = (state_q == StBusy) && (owner_q == OwnRd) && sdr_done;
  assign wr_adv  = (state_q == StBusy) && (owner_q == OwnWr) && sdr_done;

  sdram_burst_addr_gen #(
    .ADDR_W     (ADDR_W),
    .BASE       (RD_BASE),
    .BURST_LEN  (BURST_LEN),
    .FRAME_WORDS(FRAME_WORDS)
  ) u_rd_addr (
    .clk  (clk),
    .rst_n(rst_n),
    .set  (rd_addr_set),
    .adv  (rd_adv),
    .busy (rd_busy),
    .addr (rd_addr)
  );

  sdram_burst_addr_gen #(
    .ADDR_W     (ADDR_W),
    .BASE       (WR_BASE),
    .BURST_LEN  (BURST_LEN),
    .FRAME_WORDS(FRAME_WORDS)
  ) u_wr_addr (
    .clk  (clk),
    .rst_n(rst_n),
    .set  (wr_addr_set),
    .adv  (wr_adv),
    .busy (wr_busy),
    .addr (wr_addr)
  );

  assign sdr_req  = (state_q == StReq);
  assign sdr_we   = we_q;
  assign sdr_addr = addr_q;
  assign rd_grant = (state_q == StBusy) && (owner_q == OwnRd);
  assign wr_grant = (state_q == StBusy) && (owner_q == OwnWr);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench: expected bursts are queued as stimulus is set up and checked as sdr_req appears.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_req = 1'b0, rd_addr_set = 1'b0, wr_req = 1'b0, wr_addr_set = 1'b0;
  logic        sdr_ack = 1'b0, sdr_done = 1'b0;
  logic        sdr_req, sdr_we, rd_grant, wr_grant;
  logic [23:0] sdr_addr;

  typedef struct packed {
    logic        we;
    logic [23:0] addr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  sdram_port_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_req     (rd_req),
    .rd_addr_set(rd_addr_set),
    .wr_req     (wr_req),
    .wr_addr_set(wr_addr_set),
    .sdr_req    (sdr_req),
    .sdr_we     (sdr_we),
    .sdr_addr   (sdr_addr),
    .sdr_ack    (sdr_ack),
    .sdr_done   (sdr_done),
    .rd_grant   (rd_grant),
    .wr_grant   (wr_grant)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic we, input int unsigned addr);
    exp_t e;
    e.we   = we;
    e.addr = addr[23:0];
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rd_req = 1'b0; wr_req = 1'b0; rd_addr_set = 1'b0; wr_addr_set = 1'b0;
    sdr_ack = 1'b0; sdr_done = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait for a request and check it against the scoreboard head.
  task automatic wait_req(output exp_t e);
    int n = 0;
    while (sdr_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'd0, sdr_req}, 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{we: 1'b1, addr: 24'hffffff};
    check("sdr_we", {31'd0, sdr_we}, {31'd0, e.we});
    check("sdr_addr", {8'd0, sdr_addr}, {8'd0, e.addr});
  endtask

  // set_mode: 0 none, 1 rd_addr_set in first busy cycle, 2 rd_addr_set with sdr_done
  task automatic serve(input int ack_dly, input int busy_len, input int set_mode);
    exp_t       e;
    logic [1:0] gexp;
    wait_req(e);
    gexp = e.we ? 2'b01 : 2'b10;
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      check("req_hold", {31'd0, sdr_req}, 32'd1);
      check("addr_hold", {8'd0, sdr_addr}, {8'd0, e.addr});
    end
    sdr_ack = 1'b1;
    @(negedge clk);
    sdr_ack = 1'b0;
    check("grant_on", {30'd0, rd_grant, wr_grant}, {30'd0, gexp});
    check("req_fall", {31'd0, sdr_req}, 32'd0);
    for (int i = 0; i < busy_len; i++) begin
      if (set_mode == 1 && i == 0) rd_addr_set = 1'b1;
      @(negedge clk);
      rd_addr_set = 1'b0;
      check("grant_hold", {30'd0, rd_grant, wr_grant}, {30'd0, gexp});
      check("inflight_addr", {8'd0, sdr_addr}, {8'd0, e.addr});
    end
    sdr_done = 1'b1;
    if (set_mode == 2) rd_addr_set = 1'b1;
    @(negedge clk);
    sdr_done = 1'b0;
    rd_addr_set = 1'b0;
    check("grant_off", {30'd0, rd_grant, wr_grant}, 32'd0);
    check("req_gap", {31'd0, sdr_req}, 32'd0);
  endtask

  initial begin
    exp_t e;
    // Reset state
    @(negedge clk);
    check("rst_req", {31'd0, sdr_req}, 32'd0);
    check("rst_we", {31'd0, sdr_we}, 32'd0);
    check("rst_grant", {30'd0, rd_grant, wr_grant}, 32'd0);
    check("rst_addr", {8'd0, sdr_addr}, 32'd0);
    rst_n = 1'b1;

    // Single read with request latency, then the following read
    rd_req = 1'b1;
    push_exp(1'b0, 0);
    push_exp(1'b0, 128);
    @(negedge clk);
    check("req_latency", {31'd0, sdr_req}, 32'd1);
    serve(2, 10, 0);
    serve(1, 3, 0);
    rd_req = 1'b0;

    // Frame wrap
    do_reset();
    rd_req = 1'b1;
    for (int i = 0; i < 256; i++) push_exp(1'b0, (i * 128) % 32640);
    for (int i = 0; i < 256; i++) serve(0, 1, 0);
    rd_req = 1'b0;

    // Starvation: R,R,R,R,W,R,R,R,R,W
    do_reset();
    rd_req = 1'b1;
    wr_req = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(1'b0, i * 128);
    push_exp(1'b1, 0);
    for (int i = 4; i < 8; i++) push_exp(1'b0, i * 128);
    push_exp(1'b1, 128);
    for (int i = 0; i < 10; i++) serve(1, 2, 0);
    rd_req = 1'b0;
    wr_req = 1'b0;

    // Rewind during a burst and coincident with sdr_done
    do_reset();
    rd_req = 1'b1;
    push_exp(1'b0, 0); push_exp(1'b0, 128); push_exp(1'b0, 256);
    for (int i = 0; i < 3; i++) serve(1, 2, 0);
    push_exp(1'b0, 384);
    serve(1, 3, 1);
    push_exp(1'b0, 0); push_exp(1'b0, 128); push_exp(1'b0, 256);
    for (int i = 0; i < 3; i++) serve(0, 2, 0);
    push_exp(1'b0, 384);
    serve(1, 3, 2);
    push_exp(1'b0, 0);
    serve(1, 1, 0);
    rd_req = 1'b0;

    // Stray ack/done in IDLE are ignored, then write-only bursts
    sdr_ack = 1'b1;
    sdr_done = 1'b1;
    @(negedge clk);
    sdr_ack = 1'b0;
    sdr_done = 1'b0;
    @(negedge clk);
    check("stray_req", {31'd0, sdr_req}, 32'd0);
    check("stray_grant", {30'd0, rd_grant, wr_grant}, 32'd0);
    wr_req = 1'b1;
    push_exp(1'b1, 0); push_exp(1'b1, 128); push_exp(1'b1, 256);
    for (int i = 0; i < 3; i++) serve(0, 2, 0);
    wr_req = 1'b0;
    rd_req = 1'b1;
    push_exp(1'b0, 128);
    serve(1, 2, 0);

    // Reset while a read at 256 is in BUSY
    push_exp(1'b0, 256);
    wait_req(e);
    sdr_ack = 1'b1;
    @(negedge clk);
    sdr_ack = 1'b0;
    check("mid_grant_on", {31'd0, rd_grant}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, sdr_req}, 32'd0);
    check("mid_rst_grant", {30'd0, rd_grant, wr_grant}, 32'd0);
    check("mid_rst_addr", {8'd0, sdr_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(1'b0, 0);
    serve(1, 2, 0);
    rd_req = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
